uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer (115200 baud debug output) between NUM_REQ byte-stream requesters, e.g. PS/2 key reporter, FIFO status reporter and an error logger.
- Requesters present multi-byte frames over a valid/ready/last handshake.
- The arbiter grants round-robin at frame boundaries and holds the grant until the last byte, so frames never interleave.
- It sequences tx_start/tx_data against tx_busy and aborts stalled frames.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_TIMEOUT, 1023, max cycles LOAD waits for the granted requester's next byte before abort.
- BUSY_TIMEOUT, 4, max cycles WAIT_BUSY waits for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of the frame
- req_ready  out  NUM_REQ  byte accepted this cycle (one-hot or zero)
- grant  out  NUM_REQ  one-hot owner of current frame; 0 when idle
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to uart_tx; stable from START through WAIT_DONE
- tx_busy  in  1  uart_tx busy flag
- active  out  1  high whenever state != IDLE
- frame_abort  out  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; grant=0, req_ready=0, tx_start=0, tx_data=0, active=0, frame_abort=0. RR pointer set so requester 0 has highest priority. Gap and busy counters cleared. Reset mid-byte drops tx_start immediately; the uart_tx instance is reset by the same rst.
- IDLE: if any req_valid, the rr_arbiter picks the first valid index searching from (last_winner+1) mod NUM_REQ. grant is registered; go LOAD. Otherwise stay.
- LOAD: req_ready[g] = (state==LOAD) & grant[g] & req_valid[g], combinational.
  - On acceptance: tx_data<=req_data[g], last_q<=req_last[g], gap counter cleared; go START.
  - Else gap counter increments. When it reaches GAP_TIMEOUT: frame_abort=1 for one cycle, grant<=0, pointer advances past g, go IDLE.
- START: tx_start=1 for exactly one cycle; go WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: go WAIT_DONE.
  - After BUSY_TIMEOUT cycles without busy: treat the byte as sent and take the WAIT_DONE exit with tx_busy=0. This covers a fast serializer or a missed flag.
- WAIT_DONE: when tx_busy=0:
  - last_q=1: grant<=0, last_winner<=g, go IDLE. The next IDLE cycle may re-arbitrate.
  - last_q=0: go LOAD (same grant).
- Frame lock: req_valid from non-granted requesters is ignored until the frame ends or aborts.
- Byte latency, best case: valid in LOAD, then START next cycle, tx_start high 1 cycle after acceptance.
- Frame-to-frame: minimum 1 IDLE cycle between frames.
- Simultaneous valids in IDLE: RR order only; no fixed priority after the first grant.
- Single requester with continuous frames: re-granted each frame (RR degenerates correctly).
- Valid dropped by the requester between IDLE and LOAD: handled by the gap timeout (abort).
- Counter widths: $clog2(GAP_TIMEOUT+1) and $clog2(BUSY_TIMEOUT+1); saturating, no wrap.
- active = (state != IDLE).

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding localparams: ARB_IDLE=0, ARB_LOAD=1, ARB_START=2, ARB_WAIT_BUSY=3, ARB_WAIT_DONE=4;
  - default timeout constants;
  - UART_CLKS_PER_BIT=217.
- One sub-module, rr_arbiter(NUM_REQ): combinational one-hot pick from req vector plus pointer input, plus a registered pointer update on an advance strobe. Everything else stays in uart_tx_arbiter.

Test Plan (bench uses a uart_tx model: busy rises 1 cycle after tx_start and lasts 20 cycles):
- Single frame: req0 sends 0xA5 then 0x1C (last) -> two tx_start pulses, tx_data 0xA5 then 0x1C, each pulse after tx_busy falls; grant=001 throughout, then 000.
- RR fairness: req0, req1 and req2 each hold one 1-byte frame (0x11, 0x22, 0x33) from reset -> order 0x11, 0x22, 0x33. Repeat with all valid -> order continues 0x11, 0x22, 0x33.
- Frame lock: req0 sends 3-byte frame 0x01, 0x02, 0x03 while req1 raises valid with 0xFF after byte 1 -> tx order 0x01, 0x02, 0x03, 0xFF; req_ready[1] stays 0 until grant=010.
- Gap timeout: req0 sends 0x10 (last=0) then drops valid; GAP_TIMEOUT=15 -> frame_abort pulses 15 cycles into LOAD, grant=000, pending req1 0x20 is granted next.
- Busy timeout: model never asserts tx_busy -> WAIT_BUSY exits after 4 cycles, frame completes, no hang.
- Reset mid-byte: assert rst during WAIT_DONE of 0x55 -> next cycle all outputs 0, state IDLE, req0 regains priority first.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
//   Shared constants and types for the debug-UART output path.
//   - ARB_* : state encodings of the uart_tx_arbiter sequencer
//   - DEF_* : default timeouts for uart_tx_arbiter
//   - UART_CLKS_PER_BIT : divider of the uart_tx serializer (115200 baud)
// ----------------------------------------------------------------------------
package ps2_pkg;

    // Sequencer state encodings.
    localparam int ARB_IDLE      = 0;
    localparam int ARB_LOAD      = 1;
    localparam int ARB_START     = 2;
    localparam int ARB_WAIT_BUSY = 3;
    localparam int ARB_WAIT_DONE = 4;

    // Default timeouts (in clk cycles).
    localparam int DEF_GAP_TIMEOUT  = 1023;
    localparam int DEF_BUSY_TIMEOUT = 4;

    // Bit period of the shared uart_tx serializer.
    localparam int UART_CLKS_PER_BIT = 217;

    // Legal requester count range.
    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'(ARB_IDLE),
        ST_LOAD      = 3'(ARB_LOAD),
        ST_START     = 3'(ARB_START),
        ST_WAIT_BUSY = 3'(ARB_WAIT_BUSY),
        ST_WAIT_DONE = 3'(ARB_WAIT_DONE)
    } arb_state_e;

endpackage : ps2_pkg

// File: rtl/uart_tx_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin picker. The pointer is kept one-hot and marks the requester
//   with the highest priority. The pick is purely combinational; the pointer
//   moves to the position just after the winner when advance_i is strobed.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (requester 0 first)
//   req_i      in   request vector
//   advance_i  in   one-cycle strobe: move pointer past winner_i
//   winner_i   in   one-hot owner of the frame that just ended/aborted
//   pick_o     out  one-hot pick (zero when req_i is zero)
// ----------------------------------------------------------------------------
module rr_arbiter
    import ps2_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    input  logic [NUM_REQ-1:0] winner_i,
    output logic [NUM_REQ-1:0] pick_o
);

    logic [NUM_REQ-1:0] ptr_q;
    logic [NUM_REQ-1:0] ptr_d;
    logic [NUM_REQ-1:0] winner_rot;
    logic [NUM_REQ-1:0] thermo;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pool;

    // Rotate the winner left by one so its successor becomes top priority.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign winner_rot[(gi + 1) % NUM_REQ] = winner_i[gi];
    end

    always_comb begin
        // Bits at or above the pointer position form the first search window;
        // if nothing is pending there the search wraps to the full vector.
        thermo = ~(ptr_q - NUM_REQ'(1));
        masked = req_i & thermo;
        pool   = (|masked) ? masked : req_i;
        // Isolate the lowest set bit of the chosen window.
        pick_o = pool & (~pool + NUM_REQ'(1));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (|winner_i)) begin
            ptr_d = winner_rot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= NUM_REQ'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
//   A requester wins at a frame boundary (round-robin) and keeps the grant
//   until its last byte has been shifted out, so frames never interleave.
//   Each byte is handed to uart_tx with a one-cycle tx_start, then the
//   sequencer waits for tx_busy to rise and fall before loading the next one.
//   Frames whose next byte never shows up are abandoned after GAP_TIMEOUT.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   req_valid    in   [NUM_REQ]   per-requester byte valid
//   req_data     in   [8*NUM_REQ] requester i on bits [8i+7:8i]
//   req_last     in   [NUM_REQ]   byte is the final byte of its frame
//   req_ready    out  [NUM_REQ]   byte accepted this cycle (one-hot or zero)
//   grant        out  [NUM_REQ]   one-hot frame owner, zero when idle
//   tx_start     out  one-cycle start pulse to uart_tx
//   tx_data      out  [8] byte to uart_tx, held from START to WAIT_DONE
//   tx_busy      in   uart_tx busy flag
//   active       out  sequencer not idle
//   frame_abort  out  one-cycle pulse when a stalled frame is abandoned
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import ps2_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int GAP_TIMEOUT  = DEF_GAP_TIMEOUT,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 active,
    output logic                 frame_abort
);

    localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);
    localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);

    // The counters abort/exit on the cycle in which they would reach the
    // timeout value, so the limit compare is against timeout-1.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_TIMEOUT);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TIMEOUT - 1);
    localparam logic [BUSY_W-1:0] BUSY_MAX  = BUSY_W'(BUSY_TIMEOUT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e         state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q,    last_d;
    logic [GAP_W-1:0]   gap_q,     gap_d;
    logic [BUSY_W-1:0]  busy_q,    busy_d;

    logic               advance;
    logic               byte_done;
    logic [NUM_REQ-1:0] pick;

    // ------------------------------------------------------------------
    // Granted-requester byte select (AND-OR mux on the one-hot grant)
    // ------------------------------------------------------------------
    logic [7:0] data_masked [NUM_REQ];
    logic [7:0] sel_data;
    logic       sel_valid;
    logic       sel_last;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
        assign data_masked[gi] = req_data[8*gi +: 8] & {8{grant_q[gi]}};
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | data_masked[i];
        end
    end

    assign sel_valid = |(grant_q & req_valid);
    assign sel_last  = |(grant_q & req_last);

    // ------------------------------------------------------------------
    // Round-robin picker; only consulted in IDLE, so non-granted
    // requesters are ignored for the whole frame.
    // ------------------------------------------------------------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .advance_i (advance),
        .winner_i  (grant_q),
        .pick_o    (pick)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        req_ready   = '0;
        frame_abort = 1'b0;
        advance     = 1'b0;
        byte_done   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    gap_d   = '0;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                req_ready = grant_q & req_valid;
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    gap_d     = '0;
                    state_d   = ST_START;
                end else if (gap_q >= GAP_LAST) begin
                    // Requester went quiet mid-frame: drop it and move the
                    // pointer past it so it cannot immediately win again.
                    frame_abort = 1'b1;
                    grant_d     = '0;
                    advance     = 1'b1;
                    gap_d       = '0;
                    state_d     = ST_IDLE;
                end else if (gap_q != GAP_MAX) begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_START: begin
                busy_d  = '0;
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    busy_d  = '0;
                    state_d = ST_WAIT_DONE;
                end else if (busy_q >= BUSY_LAST) begin
                    // Busy never seen: assume the serializer already finished.
                    busy_d    = '0;
                    byte_done = 1'b1;
                end else if (busy_q != BUSY_MAX) begin
                    busy_d = busy_q + BUSY_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        // Common exit once a byte has left the serializer.
        if (byte_done) begin
            if (last_q) begin
                grant_d = '0;
                advance = 1'b1;
                state_d = ST_IDLE;
            end else begin
                gap_d   = '0;
                state_d = ST_LOAD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            gap_q     <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == ST_START);
    assign active   = (state_q != ST_IDLE);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=3, GAP_TIMEOUT=15,
//   BUSY_TIMEOUT=4). A uart_tx stand-in raises busy one cycle after tx_start
//   and holds it for 20 cycles. Requesters are byte queues {last,data}.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     grant;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             active;
    logic             frame_abort;

    int compared   = 0;
    int mismatched = 0;

    // requester queues, entries are {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    // monitor logs
    logic [7:0] log_data[$];
    int         log_cyc[$];
    logic [2:0] log_grant[$];
    int         abort_cyc[$];
    logic [2:0] post_abort_grant  = 3'b111;
    logic       post_abort_active = 1'b1;
    logic       abort_prev        = 1'b0;
    int         cyc               = 0;
    int         lock_viol         = 0;
    int         ready1_granted    = 0;

    // uart_tx stand-in
    int   busy_cnt = 0;
    logic busy_en  = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .GAP_TIMEOUT  (15),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active      (active),
        .frame_abort (frame_abort)
    );

    always @(posedge clk) begin
        if (rst)                      busy_cnt <= 0;
        else if (busy_en && tx_start) busy_cnt <= 20;
        else if (busy_cnt != 0)       busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Requester driver: pop the head that was accepted, present the next one.
    initial begin : driver
        logic [N-1:0] snap;
        logic [8:0]   item;
        logic [9:0]   h0, h1, h2;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            snap = req_ready;
            @(posedge clk);
            #1;
            if (snap[0] && q0.size() > 0) item = q0.pop_front();
            if (snap[1] && q1.size() > 0) item = q1.pop_front();
            if (snap[2] && q2.size() > 0) item = q2.pop_front();
            h0 = (q0.size() > 0) ? {1'b1, q0[0]} : 10'h0;
            h1 = (q1.size() > 0) ? {1'b1, q1[0]} : 10'h0;
            h2 = (q2.size() > 0) ? {1'b1, q2[0]} : 10'h0;
            req_valid = {h2[9], h1[9], h0[9]};
            req_last  = {h2[8], h1[8], h0[8]};
            req_data  = {h2[7:0], h1[7:0], h0[7:0]};
        end
    end

    // Output monitor, samples on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (abort_prev) begin
                post_abort_grant  = grant;
                post_abort_active = active;
            end
            abort_prev = frame_abort;
            if (tx_start) begin
                log_data.push_back(tx_data);
                log_cyc.push_back(cyc);
                log_grant.push_back(grant);
            end
            if (frame_abort) abort_cyc.push_back(cyc);
            if (req_ready[1] && grant !== 3'b010) lock_viol++;
            if (req_ready[1] && grant === 3'b010) ready1_granted++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", compared, mismatched);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_cyc.delete();
        log_grant.delete();
        abort_cyc.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            step();
            k++;
        end
        compared++;
        if (log_data.size() < n) begin
            mismatched++;
            $display("FAIL %s: tx_start pulses seen %0d, required %0d", name, log_data.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((active || tx_busy || q0.size() > 0 || q1.size() > 0 || q2.size() > 0) && k < budget) begin
            step();
            k++;
        end
        step();
        compared++;
        if (active !== 1'b0) begin
            mismatched++;
            $display("FAIL %s: active=%b, required 0 (not idle)", name, active);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        compared += 6;
        if (grant !== 3'b000)    begin mismatched++; $display("FAIL reset_grant: got %b required 000", grant); end
        if (req_ready !== 3'b000) begin mismatched++; $display("FAIL reset_ready: got %b required 000", req_ready); end
        if (tx_start !== 1'b0)   begin mismatched++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
        if (tx_data !== 8'h00)   begin mismatched++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        if (active !== 1'b0)     begin mismatched++; $display("FAIL reset_active: got %b required 0", active); end
        if (frame_abort !== 1'b0) begin mismatched++; $display("FAIL reset_abort: got %b required 0", frame_abort); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_rr(input string name);
        logic [7:0] exp_d[3];
        logic [2:0] exp_g[3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        exp_g = '{3'b001, 3'b010, 3'b100};
        clear_logs();
        q0.push_back(9'h111);
        q1.push_back(9'h122);
        q2.push_back(9'h133);
        wait_log(3, 300, name);
        for (int i = 0; i < 3; i++) begin
            compared += 2;
            if (log_data[i] !== exp_d[i]) begin
                mismatched++;
                $display("FAIL %s_data%0d: got %h required %h", name, i, log_data[i], exp_d[i]);
            end
            if (log_grant[i] !== exp_g[i]) begin
                mismatched++;
                $display("FAIL %s_grant%0d: got %b required %b", name, i, log_grant[i], exp_g[i]);
            end
        end
        wait_idle(200, name);
    endtask

    task automatic test_single_frame();
        clear_logs();
        q0.push_back(9'h0A5);
        q0.push_back(9'h11C);
        wait_log(2, 200, "single");
        compared += 5;
        if (log_data[0] !== 8'hA5) begin mismatched++; $display("FAIL single_b0: got %h required a5", log_data[0]); end
        if (log_data[1] !== 8'h1C) begin mismatched++; $display("FAIL single_b1: got %h required 1c", log_data[1]); end
        if (log_grant[0] !== 3'b001) begin mismatched++; $display("FAIL single_g0: got %b required 001", log_grant[0]); end
        if (log_grant[1] !== 3'b001) begin mismatched++; $display("FAIL single_g1: got %b required 001", log_grant[1]); end
        // START, WAIT_BUSY, 20 busy cycles in WAIT_DONE, LOAD, then START
        if (log_cyc[1] - log_cyc[0] !== 23) begin
            mismatched++;
            $display("FAIL single_spacing: got %0d cycles required 23", log_cyc[1] - log_cyc[0]);
        end
        wait_idle(100, "single_end");
        compared++;
        if (grant !== 3'b000) begin mismatched++; $display("FAIL single_grant_end: got %b required 000", grant); end
    endtask

    task automatic test_frame_lock();
        logic [7:0] exp_d[4];
        exp_d = '{8'h01, 8'h02, 8'h03, 8'hFF};
        clear_logs();
        lock_viol      = 0;
        ready1_granted = 0;
        q0.push_back(9'h001);
        q0.push_back(9'h002);
        q0.push_back(9'h103);
        wait_log(1, 100, "lock_first");
        q1.push_back(9'h1FF);
        wait_log(4, 400, "lock");
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (log_data[i] !== exp_d[i]) begin
                mismatched++;
                $display("FAIL lock_data%0d: got %h required %h", i, log_data[i], exp_d[i]);
            end
        end
        compared += 3;
        if (log_grant[3] !== 3'b010) begin mismatched++; $display("FAIL lock_grant3: got %b required 010", log_grant[3]); end
        if (lock_viol !== 0) begin mismatched++; $display("FAIL lock_ready1_early: got %0d cycles required 0", lock_viol); end
        if (ready1_granted !== 1) begin mismatched++; $display("FAIL lock_ready1_once: got %0d cycles required 1", ready1_granted); end
        wait_idle(100, "lock_end");
    endtask

    task automatic test_gap_timeout();
        clear_logs();
        post_abort_grant  = 3'b111;
        post_abort_active = 1'b1;
        q0.push_back(9'h010);
        wait_log(1, 100, "gap_first");
        q1.push_back(9'h120);
        wait_log(2, 300, "gap");
        compared += 6;
        if (abort_cyc.size() !== 1) begin mismatched++; $display("FAIL gap_abort_count: got %0d required 1", abort_cyc.size()); end
        // 22 cycles to get back to LOAD, then 15 LOAD cycles
        if (abort_cyc[0] - log_cyc[0] !== 36) begin
            mismatched++;
            $display("FAIL gap_abort_time: got %0d cycles after tx_start required 36", abort_cyc[0] - log_cyc[0]);
        end
        if (post_abort_grant !== 3'b000) begin mismatched++; $display("FAIL gap_grant_after: got %b required 000", post_abort_grant); end
        if (post_abort_active !== 1'b0) begin mismatched++; $display("FAIL gap_active_after: got %b required 0", post_abort_active); end
        if (log_data[1] !== 8'h20) begin mismatched++; $display("FAIL gap_next_data: got %h required 20", log_data[1]); end
        if (log_grant[1] !== 3'b010) begin mismatched++; $display("FAIL gap_next_grant: got %b required 010", log_grant[1]); end
        wait_idle(100, "gap_end");
    endtask

    task automatic test_busy_timeout();
        clear_logs();
        busy_en = 1'b0;
        q2.push_back(9'h044);
        q2.push_back(9'h145);
        wait_log(2, 100, "busy");
        compared += 4;
        if (log_data[0] !== 8'h44) begin mismatched++; $display("FAIL busy_b0: got %h required 44", log_data[0]); end
        if (log_data[1] !== 8'h45) begin mismatched++; $display("FAIL busy_b1: got %h required 45", log_data[1]); end
        if (log_grant[1] !== 3'b100) begin mismatched++; $display("FAIL busy_grant: got %b required 100", log_grant[1]); end
        // START, 4 WAIT_BUSY cycles, LOAD, then START
        if (log_cyc[1] - log_cyc[0] !== 6) begin
            mismatched++;
            $display("FAIL busy_spacing: got %0d cycles required 6", log_cyc[1] - log_cyc[0]);
        end
        wait_idle(50, "busy_end");
        busy_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        // Leave the pointer at requester 1 so the reset has to restore it.
        clear_logs();
        q0.push_back(9'h15A);
        wait_log(1, 100, "rmid_pre");
        wait_idle(100, "rmid_pre_end");
        clear_logs();
        q1.push_back(9'h155);
        wait_log(1, 100, "rmid_byte");
        repeat (5) step();
        compared += 2;
        if (active !== 1'b1) begin mismatched++; $display("FAIL rmid_busy_active: got %b required 1", active); end
        if (tx_data !== 8'h55) begin mismatched++; $display("FAIL rmid_tx_data: got %h required 55", tx_data); end
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        step();
        compared += 6;
        if (grant !== 3'b000)     begin mismatched++; $display("FAIL rmid_grant: got %b required 000", grant); end
        if (req_ready !== 3'b000) begin mismatched++; $display("FAIL rmid_ready: got %b required 000", req_ready); end
        if (tx_start !== 1'b0)    begin mismatched++; $display("FAIL rmid_tx_start: got %b required 0", tx_start); end
        if (tx_data !== 8'h00)    begin mismatched++; $display("FAIL rmid_tx_data0: got %h required 00", tx_data); end
        if (active !== 1'b0)      begin mismatched++; $display("FAIL rmid_active: got %b required 0", active); end
        if (frame_abort !== 1'b0) begin mismatched++; $display("FAIL rmid_abort: got %b required 0", frame_abort); end
        rst = 1'b0;
        clear_logs();
        q0.push_back(9'h198);
        q1.push_back(9'h199);
        wait_log(2, 200, "rmid_after");
        compared += 4;
        if (log_data[0] !== 8'h98)   begin mismatched++; $display("FAIL rmid_first_data: got %h required 98", log_data[0]); end
        if (log_grant[0] !== 3'b001) begin mismatched++; $display("FAIL rmid_first_grant: got %b required 001", log_grant[0]); end
        if (log_data[1] !== 8'h99)   begin mismatched++; $display("FAIL rmid_second_data: got %h required 99", log_data[1]); end
        if (log_grant[1] !== 3'b010) begin mismatched++; $display("FAIL rmid_second_grant: got %b required 010", log_grant[1]); end
        wait_idle(100, "rmid_end");
    endtask

    initial begin : main
        test_reset();
        $display("test_reset done: %0d compared / %0d mismatched", compared, mismatched);
        test_rr("rr_round1");
        $display("test_rr round1 done: %0d compared / %0d mismatched", compared, mismatched);
        test_rr("rr_round2");
        $display("test_rr round2 done: %0d compared / %0d mismatched", compared, mismatched);
        test_single_frame();
        $display("test_single_frame done: %0d compared / %0d mismatched", compared, mismatched);
        test_frame_lock();
        $display("test_frame_lock done: %0d compared / %0d mismatched", compared, mismatched);
        test_gap_timeout();
        $display("test_gap_timeout done: %0d compared / %0d mismatched", compared, mismatched);
        test_busy_timeout();
        $display("test_busy_timeout done: %0d compared / %0d mismatched", compared, mismatched);
        test_reset_mid();
        $display("test_reset_mid done: %0d compared / %0d mismatched", compared, mismatched);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
